// File: rtl/int_to_float_seq.sv
// int_to_float_seq: sequential integer to IEEE-754 single converter, one normalising shift per cycle; SIGNED_INPUT_EN selects two's complement input
module int_to_float_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_int,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_float,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mag, mag_in;
  logic sgn, sgn_in;
  logic [SW-1:0] sc;
  logic [62:0] ext;
  logic [7:0] exp;
  logic rnd, acc, zero;
  logic [31:0] res;
  assign acc = in_valid & in_ready;
  assign zero = in_int == '0;
`ifdef SIGNED_INPUT_EN
  assign sgn_in = in_int[WIDTH-1];
  assign mag_in = sgn_in ? -in_int : in_int;
`else
  assign sgn_in = 1'b0;
  assign mag_in = in_int;
`endif
  assign in_ready = state == IDLE;
  assign busy = state == NORM;
  assign out_valid = state == DONE;
  assign ext = {mag[WIDTH-2:0], {(64-WIDTH){1'b0}}};
  assign exp = 8'(127 + WIDTH - 1) - 8'(sc);
  assign rnd = ext[39] & ((|ext[38:0]) | ext[40]);
  assign res = {sgn, 31'({exp, ext[62:40]}) + 31'(rnd)};
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next-state: accept in IDLE, leave NORM once normalised, release DONE on handshake
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = zero ? DONE : NORM;
    else if (state == NORM && mag[WIDTH-1]) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  // datapath: capture on accept, shift until MSB set, then pack the rounded result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mag <= '0;
      sgn <= 1'b0;
      sc <= '0;
      out_float <= '0;
    end else if (acc) begin
      mag <= mag_in;
      sgn <= sgn_in;
      sc <= '0;
      if (zero) out_float <= '0;
    end else if (state == NORM) begin
      if (mag[WIDTH-1]) out_float <= res;
      else begin
        mag <= mag << 1;
        sc <= sc + 1'b1;
      end
    end
endmodule

// File: tb/tb_int_to_float_seq.sv
// tb_int_to_float_seq: directed checks of int_to_float_seq at WIDTH=16 and WIDTH=32
module tb_int_to_float_seq;
  logic clk = 0, rst = 1;
  logic v16 = 0, r16, ov16, or16 = 0, b16;
  logic [15:0] i16 = '0;
  logic [31:0] f16;
  logic v32 = 0, r32, ov32, or32 = 0, b32;
  logic [31:0] i32 = '0, f32;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  int_to_float_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
    .in_int(i16), .out_valid(ov16), .out_ready(or16), .out_float(f16), .busy(b16));
  int_to_float_seq #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32),
    .in_int(i32), .out_valid(ov32), .out_ready(or32), .out_float(f32), .busy(b32));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic conv(input bit w, input logic [31:0] val, input logic [31:0] ef, input int el, input bit bp);
    int n;
    @(negedge clk);
    chk("in_ready_pre", {31'b0, w ? r32 : r16}, 1);
    if (w) begin v32 = 1; i32 = val; end else begin v16 = 1; i16 = val[15:0]; end
    @(posedge clk); #1;
    v32 = 0; v16 = 0; i16 = 16'hA5A5; i32 = 32'h5A5A5A5A;
    chk("busy_after_accept", {31'b0, w ? b32 : b16}, {31'b0, el > 1});
    n = 1;
    while (!(w ? ov32 : ov16) && n < 100) begin @(posedge clk); #1; n++; end
    chk("latency", n, el);
    chk("out_float", w ? f32 : f16, ef);
    if (bp) begin
      v16 = 1; i16 = 16'h0007;
      repeat (5) begin
        @(posedge clk); #1;
        chk("bp_valid", {31'b0, ov16}, 1);
        chk("bp_float", f16, ef);
        chk("bp_ready", {31'b0, r16}, 0);
      end
      v16 = 0;
    end
    @(negedge clk);
    if (w) or32 = 1; else or16 = 1;
    @(posedge clk); #1;
    or32 = 0; or16 = 0;
    chk("idle_after", {31'b0, w ? r32 : r16}, 1);
    chk("valid_low", {31'b0, w ? ov32 : ov16}, 0);
    chk("retain", w ? f32 : f16, ef);
  endtask

  initial begin
    #2;
    chk("rst_ready", {31'b0, r16}, 1);
    chk("rst_valid", {31'b0, ov16}, 0);
    chk("rst_busy", {31'b0, b16}, 0);
    chk("rst_float", f16, 0);
    chk("rst_float32", f32, 0);
    @(negedge clk); rst = 0;
    conv(0, 32'd1, 32'h3F800000, 17, 0);
    conv(0, 32'd9, 32'h41100000, 14, 1);
`ifdef SIGNED_INPUT_EN
    conv(0, 32'h8000, 32'hC7000000, 2, 0);
    conv(0, 32'hFFFF, 32'hBF800000, 17, 0);
`else
    conv(0, 32'h8000, 32'h47000000, 2, 0);
    conv(0, 32'hFFFF, 32'h477FFF00, 2, 0);
`endif
    conv(0, 32'd0, 32'h00000000, 1, 0);
`ifdef SIGNED_INPUT_EN
    conv(1, 32'hFFFFFFFF, 32'hBF800000, 33, 0);
`else
    conv(1, 32'hFFFFFFFF, 32'h4F800000, 2, 0);
`endif
    conv(1, 32'h01000001, 32'h4B800000, 9, 0);
    conv(1, 32'h01000003, 32'h4B800002, 9, 0);
    @(negedge clk);
    v16 = 1; i16 = 16'd1;
    @(posedge clk); #1;
    v16 = 0;
    repeat (4) @(posedge clk);
    #1 chk("mid_norm_busy", {31'b0, b16}, 1);
    #2 rst = 1;
    #1;
    chk("abort_valid", {31'b0, ov16}, 0);
    chk("abort_ready", {31'b0, r16}, 1);
    chk("abort_busy", {31'b0, b16}, 0);
    chk("abort_float", f16, 0);
    @(negedge clk); rst = 0;
    conv(0, 32'd3, 32'h40400000, 16, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
